// File: rtl/ahb_pkg.sv
// ahb_pkg: shared AHB-Lite encodings and the master's error-handling state type.
//   HTRANS_*       transfer type encodings
//   HSIZE_WORD     32-bit transfer size
//   HBURST_SINGLE  single-beat burst encoding
//   HPROT_DEFAULT  non-cacheable, non-bufferable, privileged data access
//   state_t        RUN / ERR1 / ERR2 master state
package ahb_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [2:0] HSIZE_WORD    = 3'b010;
  localparam logic [2:0] HBURST_SINGLE = 3'b000;
  localparam logic [3:0] HPROT_DEFAULT = 4'b0011;

  typedef enum logic [1:0] {
    RUN,
    ERR1,
    ERR2
  } state_t;

endpackage

// File: rtl/ahb_master.sv
// ahb_master: single-beat AHB-Lite master with one address-phase slot (A)
// and one data-phase slot (D), giving one transfer per cycle at zero wait.
//   i_clk_ahb, i_rst_ahb          clock, async active-high reset
//   i_valid/i_rd0_wr1/i_addr/i_wr_data, o_ready   request handshake
//   o_done/o_err/o_rd_data        completion pulse, error flag, read data
//   o_h*                          AHB-Lite master outputs (registered)
//   i_hready/i_hresp/i_hrdata     AHB-Lite slave response
module ahb_master
  import ahb_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  i_clk_ahb,
  input  logic                  i_rst_ahb,
  input  logic                  i_valid,
  input  logic                  i_rd0_wr1,
  input  logic [ADDR_WIDTH-1:0] i_addr,
  input  logic [DATA_WIDTH-1:0] i_wr_data,
  output logic                  o_ready,
  output logic                  o_done,
  output logic                  o_err,
  output logic [DATA_WIDTH-1:0] o_rd_data,
  output logic [ADDR_WIDTH-1:0] o_haddr,
  output logic                  o_hwrite,
  output logic [1:0]            o_htrans,
  output logic [2:0]            o_hsize,
  output logic [2:0]            o_hburst,
  output logic [3:0]            o_hprot,
  output logic                  o_hmastlock,
  output logic [DATA_WIDTH-1:0] o_hwdata,
  input  logic                  i_hready,
  input  logic                  i_hresp,
  input  logic [DATA_WIDTH-1:0] i_hrdata
);

  state_t                state, state_nxt;
  logic                  a_valid, a_valid_nxt;
  logic [DATA_WIDTH-1:0] a_wdata;
  logic                  d_valid;
  logic                  d_write;
  logic                  accept;
  logic                  a_go;
  logic                  d_go;
  logic                  d_err;

  assign o_hsize     = HSIZE_WORD;
  assign o_hburst    = HBURST_SINGLE;
  assign o_hprot     = HPROT_DEFAULT;
  assign o_hmastlock = 1'b0;

  // o_haddr/o_hwrite double as the A-slot address/direction registers.
  assign o_ready = (!a_valid || (i_hready && !i_hresp)) && (state == RUN);
  assign accept  = i_valid && o_ready;
  // A is only on the bus (NONSEQ) while in RUN, so only then can it advance.
  assign a_go    = a_valid && (state == RUN) && i_hready;
  assign d_go    = d_valid && i_hready;
  // Any completion in ERR2, or an HRESP seen with HREADY, ends D in error.
  assign d_err   = i_hresp || (state == ERR2);
  assign a_valid_nxt = (a_valid && !a_go) || accept;

  always_comb begin
    state_nxt = state;
    case (state)
      RUN:     if (d_valid && i_hresp && !i_hready) state_nxt = ERR1;
      ERR1:    state_nxt = ERR2;
      ERR2:    if (i_hready) state_nxt = RUN;
      default: state_nxt = RUN;
    endcase
  end

  always_ff @(posedge i_clk_ahb or posedge i_rst_ahb) begin
    if (i_rst_ahb) begin
      state     <= RUN;
      a_valid   <= 1'b0;
      a_wdata   <= '0;
      d_valid   <= 1'b0;
      d_write   <= 1'b0;
      o_haddr   <= '0;
      o_hwrite  <= 1'b0;
      o_htrans  <= HTRANS_IDLE;
      o_hwdata  <= '0;
      o_done    <= 1'b0;
      o_err     <= 1'b0;
      o_rd_data <= '0;
    end else begin
      state   <= state_nxt;
      a_valid <= a_valid_nxt;
      if (accept) begin
        o_haddr  <= i_addr;
        o_hwrite <= i_rd0_wr1;
        a_wdata  <= i_wr_data;
      end
      if (a_go) begin
        d_write  <= o_hwrite;
        o_hwdata <= a_wdata;
      end
      d_valid <= a_go || (d_valid && !d_go);
      o_done  <= d_go;
      o_err   <= d_go && d_err;
      if (d_go) begin
        o_rd_data <= (d_err || d_write) ? '0 : i_hrdata;
      end
      // Registered HTRANS looks ahead so a retained A re-issues in the first RUN cycle.
      o_htrans <= (a_valid_nxt && (state_nxt == RUN)) ? HTRANS_NONSEQ : HTRANS_IDLE;
    end
  end

endmodule
